// File: rtl/fetch_queue.sv
// fetch_queue
//   Pipelined fetch front end. Owns the PC and drives the combinational
//   instruction-memory address. It buffers fetched {pc, instruction} pairs in a
//   DEPTH-entry prefetch FIFO and presents the head entry to decode over a
//   valid/ready handshake. It also handles redirect/flush, HALT detection and
//   illegal-redirect error pulses.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   imem_addr    instruction memory address (the PC register)
//   imem_data    instruction at imem_addr, valid in the same cycle
//   redirect_en  taken branch/jump: flush the queue and load redirect_pc
//   redirect_pc  redirect target (bit 0 is forced to 0 when loaded)
//   out_valid    head entry available
//   out_ready    decode accepts the head entry
//   out_instr    head instruction
//   out_pc       PC of the head instruction
//   out_pc_next  out_pc + PC_INC (wraps)
//   halted       a HALT has been enqueued and fetching has stopped
//   err          one-cycle pulse after a misaligned or post-drain redirect
module fetch_queue #(
  parameter int unsigned     WIDTH    = 16,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_INC   = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [4:0]      HALT_OPC = 5'b00000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             redirect_en,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pc_next,
  output logic             halted,
  output logic             err
);

  localparam int unsigned      PTR_W     = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(PC_INC);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] pc_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic             halted_reg;
  logic             err_reg;

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];

  logic fetch;
  logic deq;
  logic is_halt;
  logic err_next;

  // Fullness is judged on the current count, so a dequeue in the same cycle
  // does not let a fetch in; the fetch resumes on the following edge.
  assign fetch    = ~halted_reg & (count_reg < DEPTH_CNT) & ~redirect_en;
  assign deq      = out_valid & out_ready;
  assign is_halt  = (imem_data[WIDTH-1 -: 5] == HALT_OPC);
  assign err_next = redirect_en &
                    (redirect_pc[0] | (halted_reg & (count_reg == '0)));

  assign imem_addr   = pc_reg;
  assign out_valid   = (count_reg != '0);
  assign out_instr   = instr_mem[rd_ptr_reg];
  assign out_pc      = pc_mem[rd_ptr_reg];
  assign out_pc_next = out_pc + PC_STEP;
  assign halted      = halted_reg;
  assign err         = err_reg;

  // Entry storage. Each slot resets to zero so the head reads a deterministic
  // value while the queue is empty.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          instr_mem[gi] <= '0;
          pc_mem[gi]    <= '0;
        end else if (fetch && (wr_ptr_reg == PTR_W'(gi))) begin
          instr_mem[gi] <= imem_data;
          pc_mem[gi]    <= pc_reg;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      halted_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      err_reg <= err_next;
      if (redirect_en) begin
        // A head transfer in this cycle is treated as consumed; the flush
        // discards everything regardless.
        pc_reg     <= {redirect_pc[WIDTH-1:1], 1'b0};
        count_reg  <= '0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        halted_reg <= 1'b0;
      end else begin
        if (fetch) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
          pc_reg     <= pc_reg + PC_STEP;
          if (is_halt) begin
            halted_reg <= 1'b1;
          end
        end
        if (deq) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        if (fetch && !deq) begin
          count_reg <= count_reg + 1'b1;
        end else if (deq && !fetch) begin
          count_reg <= count_reg - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. The reference model holds the prefetch buffer as
// a queue of {pc, instr} records and applies the fetch/dequeue/redirect/halt
// rules once per clock edge.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_next;
  logic        halted;
  logic        err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Instruction memory contents
  logic        const_mode = 1'b1;
  logic [15:0] const_val  = 16'h1234;
  logic [15:0] salt       = 16'h0000;
  logic [15:0] halt_addr  = 16'hFFFF;

  always #5 clk = ~clk;

  always_comb begin
    if (const_mode)
      imem_data = const_val;
    else if (imem_addr == halt_addr)
      imem_data = 16'h0000;
    else
      imem_data = (imem_addr ^ salt) | 16'h8000;
  end

  fetch_queue #(
    .WIDTH(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'h0000), .HALT_OPC(5'b00000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_next(out_pc_next),
    .halted(halted), .err(err)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [15:0] m_pc;
  logic        m_halted;
  logic        m_err;

  function automatic logic [15:0] imem_fn(input logic [15:0] a);
    if (const_mode) return const_val;
    if (a == halt_addr) return 16'h0000;
    return (a ^ salt) | 16'h8000;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = 16'h0000;
    m_halted = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input logic re, input logic [15:0] rpc, input logic rdy);
    ent_t e;
    bit   full;
    m_err = re && (rpc[0] || (m_halted && m_q.size() == 0));
    if (re) begin
      m_q.delete();
      m_pc     = rpc & 16'hFFFE;
      m_halted = 1'b0;
    end else begin
      full = (m_q.size() == 4);
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (!m_halted && !full) begin
        e.pc    = m_pc;
        e.instr = imem_fn(m_pc);
        m_q.push_back(e);
        if (e.instr[15:11] == 5'b00000) m_halted = 1'b1;
        m_pc = m_pc + 16'd2;
      end
    end
  endtask

  // Packed view of everything observable: {valid, pc, instr, pc_next, imem, halted, err}.
  // Head fields are zeroed while nothing is valid.
  function automatic logic [66:0] dut_snap();
    if (out_valid)
      return {1'b1, out_pc, out_instr, out_pc_next, imem_addr, halted, err};
    return {1'b0, 48'h0, imem_addr, halted, err};
  endfunction

  function automatic logic [66:0] model_snap();
    if (m_q.size() != 0)
      return {1'b1, m_q[0].pc, m_q[0].instr, m_q[0].pc + 16'd2, m_pc, m_halted, m_err};
    return {1'b0, 48'h0, m_pc, m_halted, m_err};
  endfunction

  // Drive one cycle's inputs, advance through the edge and the model, then
  // settle 1 time unit past the edge for sampling.
  task automatic tick(input logic re, input logic [15:0] rpc, input logic rdy);
    redirect_en = re;
    redirect_pc = rpc;
    out_ready   = rdy;
    @(posedge clk);
    model_step(re, rpc, rdy);
    #1;
    redirect_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [66:0] got, exp;
    const_mode = 1'b1;
    apply_reset();
    got = dut_snap(); exp = model_snap();
    check_cnt++;
    if (got !== exp) $display("FAIL reset_state: got %h expected %h", got, exp);
    else pass_cnt++;
    check_cnt++;
    if ({out_pc, out_instr} !== 32'h0)
      $display("FAIL reset_storage: got pc=%h instr=%h expected 0/0", out_pc, out_instr);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [66:0] got, exp;
    const_mode = 1'b1; const_val = 16'h1234;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      got = dut_snap(); exp = model_snap();
      check_cnt++;
      if (got !== exp) $display("FAIL stream[%0d]: got %h expected %h", i, got, exp);
      else pass_cnt++;
      check_cnt++;
      if (out_pc !== 16'(2 * i) || out_pc_next !== 16'(2 * i + 2) || !out_valid)
        $display("FAIL stream_pc[%0d]: got pc=%h next=%h v=%b expected pc=%h", i,
                 out_pc, out_pc_next, out_valid, 16'(2 * i));
      else pass_cnt++;
    end
  endtask

  task automatic test_full();
    logic [66:0] got, exp;
    const_mode = 1'b1;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 16'h0, 1'b0);
      got = dut_snap(); exp = model_snap();
      check_cnt++;
      if (got !== exp) $display("FAIL full_fill[%0d]: got %h expected %h", i, got, exp);
      else pass_cnt++;
    end
    check_cnt++;
    if (imem_addr !== 16'h0008) $display("FAIL full_hold: got imem_addr=%h expected 0008", imem_addr);
    else pass_cnt++;
    tick(1'b0, 16'h0, 1'b1);
    got = dut_snap(); exp = model_snap();
    check_cnt++;
    if (got !== exp || out_pc !== 16'h0002 || imem_addr !== 16'h0008)
      $display("FAIL full_deq: got %h expected %h", got, exp);
    else pass_cnt++;
    tick(1'b0, 16'h0, 1'b0);
    got = dut_snap(); exp = model_snap();
    check_cnt++;
    if (got !== exp || imem_addr !== 16'h000A)
      $display("FAIL full_resume: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_redirect();
    logic [66:0] got, exp;
    const_mode = 1'b1;
    apply_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 16'h0, 1'b0);
    tick(1'b1, 16'h0040, 1'b0);
    got = dut_snap(); exp = model_snap();
    check_cnt++;
    if (got !== exp || out_valid !== 1'b0 || imem_addr !== 16'h0040)
      $display("FAIL redirect_flush: got %h expected %h", got, exp);
    else pass_cnt++;
    tick(1'b0, 16'h0, 1'b1);
    got = dut_snap(); exp = model_snap();
    check_cnt++;
    if (got !== exp || out_pc !== 16'h0040 || !out_valid)
      $display("FAIL redirect_first: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    logic [66:0] got, exp;
    const_mode = 1'b0; salt = 16'($urandom); halt_addr = 16'h0006;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      got = dut_snap(); exp = model_snap();
      check_cnt++;
      if (got !== exp) $display("FAIL halt_run[%0d]: got %h expected %h", i, got, exp);
      else pass_cnt++;
      if (i == 3) begin
        check_cnt++;
        if (halted !== 1'b1 || imem_addr !== 16'h0008)
          $display("FAIL halt_set: got halted=%b imem=%h expected 1/0008", halted, imem_addr);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 16'h0008)
      $display("FAIL halt_drained: got v=%b h=%b imem=%h expected 0/1/0008", out_valid, halted, imem_addr);
    else pass_cnt++;
    tick(1'b1, 16'h0010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      got = dut_snap(); exp = model_snap();
      check_cnt++;
      if (got !== exp) $display("FAIL halt_resume[%0d]: got %h expected %h", i, got, exp);
      else pass_cnt++;
      tick(1'b0, 16'h0, 1'b1);
    end
  endtask

  task automatic test_err();
    logic [66:0] got, exp;
    const_mode = 1'b0; salt = 16'($urandom); halt_addr = 16'h0024;
    apply_reset();
    tick(1'b1, 16'h0021, 1'b1);
    got = dut_snap(); exp = model_snap();
    check_cnt++;
    if (got !== exp || err !== 1'b1 || imem_addr !== 16'h0020)
      $display("FAIL err_misalign: got %h expected %h", got, exp);
    else pass_cnt++;
    tick(1'b0, 16'h0, 1'b1);
    check_cnt++;
    if (err !== 1'b0) $display("FAIL err_pulse: got err=%b expected 0", err);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) tick(1'b0, 16'h0, 1'b1);
    tick(1'b1, 16'h0030, 1'b1);
    got = dut_snap(); exp = model_snap();
    check_cnt++;
    if (got !== exp || err !== 1'b1 || halted !== 1'b0)
      $display("FAIL err_drain: got %h expected %h", got, exp);
    else pass_cnt++;
    tick(1'b0, 16'h0, 1'b1);
    check_cnt++;
    if (err !== 1'b0) $display("FAIL err_drain_pulse: got err=%b expected 0", err);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [66:0] got, exp;
    logic        re, rdy;
    logic [15:0] rpc;
    const_mode = 1'b0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        salt      = 16'($urandom);
        halt_addr = 16'($urandom_range(0, 31) * 2);
      end
      rdy = ($urandom_range(0, 3) != 0);
      re  = ($urandom_range(0, 15) == 0);
      rpc = 16'($urandom_range(0, 63));
      tick(re, rpc, rdy);
      got = dut_snap(); exp = model_snap();
      check_cnt++;
      if (got !== exp) $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    const_mode = 1'b0; salt = 16'($urandom); halt_addr = 16'h0002;
    apply_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 16'h0, 1'b0);
    check_cnt++;
    if (out_valid !== 1'b1 || halted !== 1'b1 || m_q.size() != 2)
      $display("FAIL arst_setup: got v=%b h=%b expected 1/1", out_valid, halted);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    check_cnt++;
    if (out_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'h0000)
      $display("FAIL arst_immediate: got v=%b h=%b imem=%h expected 0/0/0000",
               out_valid, halted, imem_addr);
    else pass_cnt++;
    apply_reset();
    const_mode = 1'b1;
    tick(1'b0, 16'h0, 1'b1);
    check_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0000 || imem_addr !== 16'h0002)
      $display("FAIL arst_restart: got v=%b pc=%h imem=%h expected 1/0000/0002",
               out_valid, out_pc, imem_addr);
    else pass_cnt++;
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_halt();
    test_err();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
